rect_plotter: RTL and testbench

RECT_PLOTTER -- requirements
Module: rect_plotter

---
 rtl/rect_plotter.sv | 113 +++++++++++
 tb/tb_rect_plotter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rect_plotter.sv
// rect_plotter: raster-scans a box, its outline or the whole screen, one registered pixel strobe per cycle.
module rect_plotter #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iStart,
    input  logic [1:0]          iMode,
    input  logic [X_W-1:0]      iX,
    input  logic [Y_W-1:0]      iY,
    input  logic [X_W-1:0]      iW,
    input  logic [Y_W-1:0]      iH,
    input  logic [COLOUR_W-1:0] iColour,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
    localparam logic [X_W:0] X_LIM = (X_W+1)'(X_SCREEN_PIXELS);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(Y_SCREEN_PIXELS);
    state_t state_q, state_d;
    logic [X_W-1:0] bx_q, bx_d, w_q, w_d, xo_q, xo_d, ox_q, ox_d;
    logic [Y_W-1:0] by_q, by_d, h_q, h_d, yo_q, yo_d, oy_q, oy_d;
    logic [COLOUR_W-1:0] col_q, col_d, oc_q, oc_d;
    logic outline_q, outline_d, plot_q, plot_d;
    logic full, in_draw, on_edge;
    logic [X_W:0] sx;
    logic [Y_W:0] sy;
    // Output registers are loaded from next-state values so the first pixel appears the cycle after accept.
    always_comb begin
        state_d = state_q;
        bx_d = bx_q;
        by_d = by_q;
        w_d = w_q;
        h_d = h_q;
        col_d = col_q;
        outline_d = outline_q;
        xo_d = xo_q;
        yo_d = yo_q;
        full = iMode[1] ^ iMode[0];
        case (state_q)
            IDLE: if (iStart) begin
                bx_d = full ? '0 : iX;
                by_d = full ? '0 : iY;
                w_d = full ? X_W'(X_SCREEN_PIXELS) : iW;
                h_d = full ? Y_W'(Y_SCREEN_PIXELS) : iH;
                col_d = (iMode == 2'b01) ? '0 : iColour;
                outline_d = iMode == 2'b11;
                xo_d = '0;
                yo_d = '0;
                state_d = (w_d == '0 || h_d == '0) ? DONE : DRAW;
            end
            DRAW: begin
                state_d = (xo_q == w_q - X_W'(1) && yo_q == h_q - Y_W'(1)) ? DONE : DRAW;
                xo_d = (xo_q == w_q - X_W'(1)) ? '0 : xo_q + X_W'(1);
                yo_d = (xo_q == w_q - X_W'(1)) ? yo_q + Y_W'(1) : yo_q;
            end
            default: state_d = IDLE;
        endcase
        in_draw = state_d == DRAW;
        sx = {1'b0, bx_d} + {1'b0, xo_d};
        sy = {1'b0, by_d} + {1'b0, yo_d};
        on_edge = xo_d == '0 || xo_d == w_d - X_W'(1) || yo_d == '0 || yo_d == h_d - Y_W'(1);
        ox_d = in_draw ? sx[X_W-1:0] : '0;
        oy_d = in_draw ? sy[Y_W-1:0] : '0;
        oc_d = in_draw ? col_d : '0;
        plot_d = in_draw && sx < X_LIM && sy < Y_LIM && (!outline_d || on_edge);
    end
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state_q <= IDLE;
            bx_q <= '0;
            by_q <= '0;
            w_q <= '0;
            h_q <= '0;
            col_q <= '0;
            outline_q <= 1'b0;
            xo_q <= '0;
            yo_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
            oc_q <= '0;
            plot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q <= bx_d;
            by_q <= by_d;
            w_q <= w_d;
            h_q <= h_d;
            col_q <= col_d;
            outline_q <= outline_d;
            xo_q <= xo_d;
            yo_q <= yo_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            oc_q <= oc_d;
            plot_q <= plot_d;
        end
    end
    assign oX = ox_q;
    assign oY = oy_q;
    assign oColour = oc_q;
    assign oPlot = plot_q;
    assign oBusy = state_q != IDLE;
    assign oDone = state_q == DONE;
endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter: randomized and directed commands checked cycle by cycle against a pixel-list model.
module tb_rect_plotter;
    logic iClock = 1'b0, iResetn = 1'b0, iStart = 1'b0;
    logic [1:0] iMode = '0;
    logic [7:0] iX = '0, iW = '0;
    logic [6:0] iY = '0, iH = '0;
    logic [2:0] iColour = '0;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic oPlot, oBusy, oDone;
    int checks = 0, errors = 0;

    rect_plotter dut (
        .iClock(iClock), .iResetn(iResetn), .iStart(iStart), .iMode(iMode),
        .iX(iX), .iY(iY), .iW(iW), .iH(iH), .iColour(iColour),
        .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {oBusy, oDone, oPlot, oX, oY, oColour}, 0);
    endtask

    function automatic bit exp_plot(int mode, int bx, int by, int w, int h, int xo, int yo);
        if (bx + xo >= 160 || by + yo >= 120) return 1'b0;
        if (mode == 3) return xo == 0 || xo == w - 1 || yo == 0 || yo == h - 1;
        return 1'b1;
    endfunction

    task automatic scramble();
        iMode = 2'($urandom);
        iX = 8'($urandom);
        iY = 7'($urandom);
        iW = 8'($urandom);
        iH = 7'($urandom);
        iColour = 3'($urandom);
    endtask

    // Called at a negedge with the DUT idle; issues one command and follows it to IDLE.
    task automatic run_cmd(input int mode, x, y, w, h, col, poke_at, abort_at, output int plots);
        int bx, by, ew, eh, ec, n, xo, yo;
        bit full, ep;
        full = mode == 1 || mode == 2;
        bx = full ? 0 : x;
        by = full ? 0 : y;
        ew = full ? 160 : w;
        eh = full ? 120 : h;
        ec = mode == 1 ? 0 : col;
        iMode = 2'(mode);
        iX = 8'(x);
        iY = 7'(y);
        iW = 8'(w);
        iH = 7'(h);
        iColour = 3'(col);
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        scramble();
        plots = 0;
        n = ew * eh;
        for (int i = 0; i < n; i++) begin
            xo = i % ew;
            yo = i / ew;
            ep = exp_plot(mode, bx, by, ew, eh, xo, yo);
            check("busy_draw", {oBusy, oDone}, 2'b10);
            check("plot", oPlot, ep);
            check("colour", oColour, ec);
            if (ep) check("xy", {oX, oY}, {8'(bx + xo), 7'(by + yo)});
            plots += int'(oPlot);
            if (i == abort_at) begin
                iResetn = 1'b0;
                @(negedge iClock);
                check_idle("reset_abort");
                iResetn = 1'b1;
                return;
            end
            if (i == poke_at) begin
                scramble();
                iStart = 1'b1;
            end
            @(negedge iClock);
            iStart = 1'b0;
        end
        check("done", {oBusy, oDone, oPlot, oX, oY, oColour}, {3'b110, 18'd0});
        @(negedge iClock);
        check_idle("after_done");
    endtask

    initial begin
        int p, mode;
        repeat (3) @(negedge iClock);
        check_idle("reset");
        iResetn = 1'b1;
        @(negedge iClock);
        check_idle("idle");
        run_cmd(0, 10, 20, 4, 4, 5, -1, -1, p);
        check("box_pulses", p, 16);
        run_cmd(0, 158, 118, 4, 4, 2, -1, -1, p);
        check("clip_pulses", p, 4);
        run_cmd(3, 0, 0, 3, 3, 7, -1, -1, p);
        check("outline_pulses", p, 8);
        run_cmd(0, 5, 5, 0, 6, 1, -1, -1, p);
        check("w0_pulses", p, 0);
        run_cmd(0, 5, 5, 7, 0, 1, -1, -1, p);
        check("h0_pulses", p, 0);
        run_cmd(0, 40, 50, 3, 2, 6, 2, -1, p);
        check("poke_pulses", p, 6);
        run_cmd(0, 10, 20, 4, 4, 5, -1, 5, p);
        run_cmd(0, 30, 40, 2, 3, 6, -1, -1, p);
        check("post_reset_pulses", p, 6);
        run_cmd(1, 9, 9, 9, 9, 7, 100, -1, p);
        check("clear_pulses", p, 19200);
        run_cmd(2, 1, 1, 1, 1, 4, -1, -1, p);
        check("fill_pulses", p, 19200);
        for (int k = 0; k < 40; k++) begin
            mode = ($urandom % 2) != 0 ? 3 : 0;
            run_cmd(mode, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 10),
                    $urandom_range(0, 10), $urandom_range(0, 7), $urandom_range(0, 20), -1, p);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
